// File: rtl/store_size_if.sv
// rtl/store_size_if.sv - store path bundle between control/memory side and store_size_unit
interface store_size_if;
    logic        start;
    logic [1:0]  store_size;
    logic [31:0] addr;
    logic [31:0] reg_data;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        misaligned;

    // control unit and data memory side
    modport master (
        output start, store_size, addr, reg_data, mem_rdata,
        input  mem_addr, mem_wdata, mem_wr, busy, done, misaligned
    );

    // store unit side
    modport slave (
        input  start, store_size, addr, reg_data, mem_rdata,
        output mem_addr, mem_wdata, mem_wr, busy, done, misaligned
    );
endinterface

// File: rtl/store_size_unit.sv
// rtl/store_size_unit.sv - sw/sh/sb store sequencer with read-modify-write; optional STORE_ALIGN_CHECK_EN
module store_size_unit (
    input  logic         clk,
    input  logic         reset,
    store_size_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic [31:0] data_q;
    logic [31:0] wdata_q;
    logic        misalign_q;

    logic        accept;
    logic        is_sub;
    logic        misalign_req;
    logic [31:0] merge_word;

    assign accept = (state_q == S_IDLE) && bus.start;
    assign is_sub = (bus.store_size == SZ_HALF) || (bus.store_size == SZ_BYTE);

`ifdef STORE_ALIGN_CHECK_EN
    // halfword needs addr[0]=0; word and reserved (treated as word) need addr[1:0]=0
    assign misalign_req = ((bus.store_size == SZ_HALF) && bus.addr[0]) ||
                          (((bus.store_size == SZ_WORD) || (bus.store_size == 2'd3)) &&
                           (bus.addr[1:0] != 2'b00));
`else
    assign misalign_req = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (misalign_req) begin
                        state_d = S_DONE;
                    end else if (is_sub) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // lane merge of the latched store value into the word just read back
    always_comb begin
        merge_word = bus.mem_rdata;
        if (size_q == SZ_HALF) begin
            if (lane_q[1]) begin
                merge_word[31:16] = data_q[15:0];
            end else begin
                merge_word[15:0] = data_q[15:0];
            end
        end else begin
            case (lane_q)
                2'd0:    merge_word[7:0]   = data_q[7:0];
                2'd1:    merge_word[15:8]  = data_q[7:0];
                2'd2:    merge_word[23:16] = data_q[7:0];
                default: merge_word[31:24] = data_q[7:0];
            endcase
        end
    end

    // request capture at start; write word is either the raw value or the merged RMW word
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= 32'd0;
            lane_q     <= 2'd0;
            size_q     <= 2'd0;
            data_q     <= 32'd0;
            wdata_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= {bus.addr[31:2], 2'b00};
            lane_q     <= bus.addr[1:0];
            size_q     <= bus.store_size;
            data_q     <= bus.reg_data;
            wdata_q    <= bus.reg_data;
            misalign_q <= misalign_req;
        end else if (state_q == S_WAIT) begin
            wdata_q    <= merge_word;
        end
    end

    // outputs decoded from registered state only
    always_comb begin
        bus.mem_addr   = addr_q;
        bus.mem_wdata  = wdata_q;
        bus.mem_wr     = (state_q == S_WRITE);
        bus.busy       = (state_q != S_IDLE);
        bus.done       = (state_q == S_DONE);
        bus.misaligned = (state_q == S_DONE) && misalign_q;
    end

endmodule

// File: doc/store_size_unit.md
# store_size_unit

Multi-cycle store path for the MIPS datapath: merges a register value (rt/B) into memory for sw, sh and sb. Word stores go straight out; halfword and byte stores do a read-modify-write of the aligned memory word. It sits between the B register and the data memory port, and is sequenced by the control unit through a start/done handshake. It is the write-to-memory counterpart of the load/write-back path.

## Interface
- No parameters; all data paths fixed at 32 bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- store_size  in  2  0 = word, 1 = halfword, 2 = byte, 3 = reserved (treated as word).
- addr  in  32  byte address from ALUOut.
- reg_data  in  32  value to store (B register).
- mem_rdata  in  32  data memory read port; valid one cycle after mem_addr is presented.
- mem_addr  out  32  word-aligned address (addr[31:2], 2'b00).
- mem_wdata  out  32  merged write word.
- mem_wr  out  1  memory write enable; high exactly one cycle per completed store.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  alignment fault pulse (only with STORE_ALIGN_CHECK_EN).

## Operation
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: on start=1, latch addr, store_size and reg_data. Word/reserved goes to WRITE; halfword/byte goes to READ.
- READ: drive mem_addr with mem_wr=0, then go to WAIT.
- WAIT: mem_rdata is valid; capture it into a merge register, then go to WRITE.
- WRITE: mem_wr=1, drive mem_addr and mem_wdata, then go to DONE.
- DONE: done=1, then go to IDLE.
- Little-endian lanes: byte k occupies bits 8k+7:8k, with k = addr[1:0].
- Word: mem_wdata = reg_data.
- Halfword: lane = addr[1]; reg_data[15:0] replaces bits 16·addr[1]+15 : 16·addr[1]; the other half comes from the captured word.
- Byte: reg_data[7:0] replaces lane addr[1:0]; the other three bytes come from the captured word.
- start is ignored while busy. Inputs are not re-sampled after IDLE, so changes to addr and reg_data mid-operation have no effect.
- reset has priority in any state: next state is IDLE and all outputs go to their reset values. A store interrupted before WRITE performs no write.
- Reset values: mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, misaligned=0; FSM in IDLE.

## Timing
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- Let E0 be the edge that samples start.
- Word: WRITE in cycle 1 (mem_wr=1), DONE in cycle 2, IDLE in cycle 3. Latency to done is 2 cycles.
- Byte/halfword: READ in cycle 1, WAIT in cycle 2 (mem_rdata captured at the edge ending cycle 2), WRITE in cycle 3, DONE in cycle 4. Latency to done is 4 cycles.
- A new start is accepted in the first cycle back in IDLE (cycle 3 or cycle 5).
- mem_addr holds its value from READ through WRITE. Outside WRITE, mem_wdata is don't-care but must be stable.

## Configuration
- STORE_ALIGN_CHECK_EN defined:
  - In IDLE, a start with a halfword and addr[0]=1, or a word and addr[1:0]≠0, moves to DONE without a write.
  - done and misaligned pulse together in that cycle; mem_wr stays 0.
  - Latency is 1 cycle.
- STORE_ALIGN_CHECK_EN undefined:
  - Offending low address bits are ignored: word uses addr[31:2]; halfword uses addr[1] only.
  - misaligned is tied to 0.

## Test plan
- sw: addr=0x0000_0010, reg_data=0xDEAD_BEEF, start → cycle 1 mem_wr=1, mem_addr=0x10, mem_wdata=0xDEAD_BEEF; cycle 2 done=1; no cycle with a read.
- sb lane 2: memory[0x20]=0x1122_3344, addr=0x22, reg_data=0xFFFF_FFAB → cycle 3 mem_wr=1, mem_wdata=0x11AB_3344; done in cycle 4.
- sh upper half: memory[0x40]=0xAAAA_BBBB, addr=0x42, reg_data=0x0000_1234 → mem_wdata=0x1234_BBBB. Same with addr=0x40 → 0xAAAA_1234.
- Back-to-back: a second start held high during busy is ignored; a start in the first IDLE cycle is accepted, and exactly two mem_wr pulses appear.
- Reset mid-operation: reset asserted in WAIT of an sb → next cycle is IDLE, all outputs 0, and mem_wr never asserts for that store.
- Alignment with the macro defined: sh to addr=0x41 → cycle 1 done=1 and misaligned=1, mem_wr=0. Without the macro: the same stimulus writes lane 0 and misaligned stays 0.
